// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of a single-port sync-read BRAM between two requesters, with read-tag return pipeline
module mem_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [7:0]  p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [7:0]  p1_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);
    logic                    r_last;
    logic [READ_LATENCY-1:0] r_tag_v;
    logic [READ_LATENCY-1:0] r_tag_p;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_push;
    always_comb begin
        w_gnt0 = !reset && p0_req && (!p1_req || r_last);
        w_gnt1 = !reset && p1_req && (!p0_req || !r_last);
        w_push = (w_gnt0 && !p0_we) || (w_gnt1 && !p1_we);
    end
    assign p0_gnt    = w_gnt0;
    assign p1_gnt    = w_gnt1;
    assign mem_en    = w_gnt0 || w_gnt1;
    assign mem_we    = w_gnt0 ? p0_we : (w_gnt1 && p1_we);
    assign mem_addr  = w_gnt0 ? p0_addr : w_gnt1 ? p1_addr : '0;
    assign mem_wdata = w_gnt0 ? p0_wdata : w_gnt1 ? p1_wdata : '0;
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_last  <= 1'b1;
            r_tag_v <= '0;
            r_tag_p <= '0;
        end else begin
            if (mem_en) r_last <= w_gnt1;
            r_tag_v <= (r_tag_v << 1) | READ_LATENCY'(w_push);
            r_tag_p <= (r_tag_p << 1) | READ_LATENCY'(w_gnt1);
        end
    end
    assign p0_rvalid = r_tag_v[READ_LATENCY-1] && !r_tag_p[READ_LATENCY-1];
    assign p1_rvalid = r_tag_v[READ_LATENCY-1] &&  r_tag_p[READ_LATENCY-1];
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;
endmodule
